// File: rtl/async_fifo_sc.sv
// Single-clock byte FIFO with registered read data and full/empty flags.
// Define ASYNC_FIFO_LEVEL_EN to add the `level` occupancy output.
module async_fifo_sc #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             wclk,
    input  logic             arst,
    input  logic             w_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef ASYNC_FIFO_LEVEL_EN
    ,output logic [AW:0]     level
`endif
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             wr_acc;
    logic             rd_acc;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_out = data_out_q;

`ifdef ASYNC_FIFO_LEVEL_EN
    assign level = wr_ptr_q - rd_ptr_q;
`endif

    // Requests are qualified with if-statements so an unknown enable
    // falls through to the idle branch; a read frees a slot for a
    // same-cycle write when full, but an empty FIFO never bypasses.
    always_comb begin
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        if (r_en && !empty) begin
            rd_acc = 1'b1;
        end
        if (w_en && (!full || rd_acc)) begin
            wr_acc = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        data_out_d = data_out_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            data_out_d = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge wclk or posedge arst) begin
        if (arst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge wclk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_async_fifo_sc.sv
// Self-checking bench for async_fifo_sc: a reference queue predicts read data
// and flags for each driven cycle, compared just after the active edge.
module tb_async_fifo_sc;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             wclk;
    logic             arst;
    logic             w_en;
    logic [WIDTH-1:0] data_in;
    logic             r_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
`ifdef ASYNC_FIFO_LEVEL_EN
    logic [AW:0]      level;
`endif

    async_fifo_sc #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .wclk     (wclk),
        .arst     (arst),
        .w_en     (w_en),
        .data_in  (data_in),
        .r_en     (r_en),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
`ifdef ASYNC_FIFO_LEVEL_EN
        ,.level   (level)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int               n_checks;
    int               n_fail;
    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_dout;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        check_val({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
        check_val({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
`ifdef ASYNC_FIFO_LEVEL_EN
        check_val({tag, ".level"}, 32'(level), 32'(model_q.size()));
`endif
    endtask

    // Drive one cycle (called #1 after a rising edge), predict, then compare.
    task automatic step(input logic we, input logic [WIDTH-1:0] din, input logic re, input string tag);
        bit rd_ok;
        bit wr_ok;
        rd_ok = re && (model_q.size() > 0);
        wr_ok = we && ((model_q.size() < DEPTH) || rd_ok);
        if (rd_ok) exp_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(din);
        w_en    = we;
        data_in = din;
        r_en    = re;
        @(posedge wclk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        check_val({tag, ".dout"}, 32'(data_out), 32'(exp_dout));
        check_flags(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] b;
        n_checks = 0;
        n_fail   = 0;
        exp_dout = '0;
        data_in  = '0;

        // Reset with enables left unknown, then idle low
        arst = 1'b1;
        #25;
        w_en = 1'b0;
        r_en = 1'b0;
        #25;
        check_val("rst.dout", 32'(data_out), 32'h0);
        check_flags("rst");
        arst = 1'b0;
        @(posedge wclk);
        #1;
        check_flags("post_rst");

        // Fill, then one dropped write
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 8'(i * 8'h11), 1'b0, "fill");
        step(1'b1, 8'hFF, 1'b0, "fill_drop");

        // Drain in order, then one read on empty
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, "drain");
        step(1'b0, 8'h00, 1'b1, "drain_empty");

        // Write+read while empty: only the write takes effect
        step(1'b1, 8'h3C, 1'b1, "wr_rd_empty");

        // Top up to full, then write+read while full
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 8'(8'h40 + i), 1'b0, "topup");
        step(1'b1, 8'hAA, 1'b1, "wr_rd_full");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, "drain2");

        // Interleaved stream across the pointer wrap
        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom_range(0, 255));
            step(1'b1, b, 1'b0, "wrap_wr");
            step(1'b0, 8'h00, 1'b1, "wrap_rd");
        end

        // Random mixed traffic
        for (int i = 0; i < 300; i++) begin
            b = 8'($urandom_range(0, 255));
            step(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)), "rand");
        end

        // Mid-operation reset
        while (model_q.size() > 0) step(1'b0, 8'h00, 1'b1, "pre_mid");
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, "mid_wr");
        arst = 1'b1;
        #2;
        model_q.delete();
        exp_dout = '0;
        check_val("mid_rst.dout", 32'(data_out), 32'h0);
        check_flags("mid_rst");
        @(negedge wclk);
        arst = 1'b0;
        @(posedge wclk);
        #1;
        step(1'b1, 8'h5C, 1'b0, "after_rst_wr");
        step(1'b0, 8'h00, 1'b1, "after_rst_rd");
        check_val("after_rst.byte", 32'(data_out), 32'h5C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
